led_state_uart_tx: RTL and testbench
====================================

LED_STATE_UART_TX -- requirements
Module: led_state_uart_tx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ_HZ, default 100000000, input clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, number of buffered bytes (power of two, at least 2).
REQ-004 Port clk  input  1  system clock, all logic on its rising edge.
REQ-005 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port in_data  input  8  byte to transmit, normally the LED state value.
REQ-007 Port in_valid  input  1  in_data is offered this cycle.
REQ-008 Port in_ready  output  1  the FIFO can accept a byte this cycle.
REQ-009 Port tx  output  1  UART serial line, idle high, registered.
REQ-010 Port busy  output  1  a frame is in progress or the FIFO is non-empty.
REQ-011 Port overflow  output  1  sticky flag: a byte was offered while in_ready was low.

Function
REQ-012 The module SHALL use CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division), which is 868 for the defaults; values below 2 are illegal.
REQ-013 The module SHALL accept a byte into the FIFO on a clock edge where in_valid and in_ready are both high.
REQ-014 in_ready SHALL be high exactly when the FIFO occupancy is below FIFO_DEPTH; a pop in the same cycle does not raise in_ready when the FIFO is full.
REQ-015 A byte offered while in_ready is low SHALL be discarded, and overflow SHALL be set on that edge and held until reset.
REQ-016 The FSM states SHALL be IDLE, START, DATA, PARITY (only when compiled in) and STOP.
REQ-017 IDLE to START SHALL happen on any edge where the FIFO is non-empty; on that edge the FSM pops the head byte into a shift register and tx goes low.
REQ-018 With an empty FIFO and IDLE, a byte accepted at edge N SHALL drive tx low from edge N+1.
REQ-019 Each state SHALL hold tx for exactly CLKS_PER_BIT clocks per bit, using a bit-period counter.
REQ-020 START SHALL drive tx 0 for one bit period.
REQ-021 DATA SHALL send 8 bits, LSB first, one bit period each, then go to PARITY (if enabled) or STOP.
REQ-022 STOP SHALL drive tx 1 for one bit period.
REQ-023 At the end of STOP the FSM SHALL go straight to START if the FIFO is non-empty, popping on that edge with no idle gap; otherwise it SHALL go to IDLE.
REQ-024 tx SHALL be 1 in IDLE.
REQ-025 A FIFO write and an FSM pop on the same edge SHALL both take effect and leave occupancy unchanged.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with bytes sent in arrival order.
REQ-027 busy SHALL be high when the FSM is not in IDLE or the FIFO occupancy is non-zero.

Reset
REQ-028 While rst_n is low, the module SHALL immediately, without waiting for a clock, force: tx=1, busy=0, overflow=0, FSM=IDLE, FIFO empty, counters 0.
REQ-029 in_ready SHALL be 1 while in reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame and discard all buffered bytes.
REQ-031 After rst_n deasserts, the first transmission SHALL need a new accepted byte.

Configuration
REQ-032 When macro LED_UART_PARITY_EN is defined, the PARITY state SHALL follow DATA and drive tx with the even-parity bit (XOR of the 8 data bits) for one bit period, giving an 11-bit frame.
REQ-033 When LED_UART_PARITY_EN is undefined, there SHALL be no PARITY state or parity logic, and the frame SHALL be 10 bits.

Verification (CLK_FREQ_HZ=1000, BAUD_RATE=100, so CLKS_PER_BIT=10, FIFO_DEPTH=4)
REQ-034 Single byte 0xA5 accepted at edge N: tx reads 0 for clocks N+1..N+10, then data bits 1,0,1,0,0,1,0,1 for 10 clocks each, then 1 for 10 clocks; busy falls after edge N+100.
REQ-035 Bytes 0x01, 0x02 accepted back-to-back: the second start bit begins exactly 100 clocks after the first; tx never idles between the two frames.
REQ-036 Six bytes 0x10..0x15 offered on consecutive edges while idle: the first is popped at once and four are buffered, so 0x10..0x14 are sent; 0x15 is dropped, in_ready goes low and overflow goes to 1.
REQ-037 rst_n pulled low at clock 35 of a 0xFF frame with two bytes queued: tx=1 at once with no clock edge needed, busy=0, in_ready=1, and no further frames follow.
REQ-038 With LED_UART_PARITY_EN defined, byte 0x07: the parity bit is 1 for 10 clocks before the stop bit; byte 0x03 gives parity bit 0; frame length is 110 clocks.

Source files
------------

// File: rtl/led_state_uart_tx.sv
// led_state_uart_tx: byte FIFO feeding an 8N1 UART transmitter (LED state reporter).
// Optional even parity bit (8E1 frame) when LED_UART_PARITY_EN is defined.
// CLK_FREQ_HZ / BAUD_RATE must be at least 2; FIFO_DEPTH must be a power of two >= 2.
module led_state_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W        = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef LED_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
`ifdef LED_UART_PARITY_EN
  logic               par_q, par_d;
`endif
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic               bit_end;
  logic               fifo_ne;

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;
  assign overflow = overflow_q;

  // Next-state, FIFO bookkeeping and registered-output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
`ifdef LED_UART_PARITY_EN
    par_d      = par_q;
`endif
    pop        = 1'b0;
    push       = in_valid && in_ready_q;
    bit_end    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    fifo_ne    = (occ_q != '0);
    tx_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fifo_ne) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef LED_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef LED_UART_PARITY_EN
      S_PARITY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (fifo_ne) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
`ifdef LED_UART_PARITY_EN
      par_d   = ^mem_q[rd_ptr_q];
`endif
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef LED_UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
    in_ready_d = (occ_d < OCC_W'(FIFO_DEPTH));
    busy_d     = (state_d != S_IDLE) || (occ_d != '0);
    overflow_d = overflow_q || (in_valid && !in_ready_q);
  end

  // State, counters, FIFO pointers and outputs; reset aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
`ifdef LED_UART_PARITY_EN
      par_q      <= 1'b0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
`ifdef LED_UART_PARITY_EN
      par_q      <= par_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_led_state_uart_tx.sv
// Testbench for led_state_uart_tx: directed scenarios plus random traffic against a
// frame-level reference model (FIFO as a queue, frame as a bit list timed in clocks).
module tb_led_state_uart_tx;

  localparam int unsigned CPB   = 10;
  localparam int unsigned DEPTH = 4;
`ifdef LED_UART_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned FRAME_LEN = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       overflow;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state
  logic [7:0] q_m [$];
  logic       act_m;
  int         t_m;
  logic [7:0] cur_m;
  logic       ovf_m;

  logic tx_log [$];
  logic busy_log [$];

  led_state_uart_tx #(
    .CLK_FREQ_HZ(1000),
    .BAUD_RATE  (100),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level for bit slot idx of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef LED_UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    q_m.delete();
    act_m = 1'b0;
    t_m   = 0;
    cur_m = 8'h00;
    ovf_m = 1'b0;
  endtask

  // One rising edge of the model: finish/advance frame, start next, then enqueue.
  task automatic model_edge(input logic v, input logic [7:0] d);
    logic acc;
    acc = v && (q_m.size() < DEPTH);
    if (v && !acc) ovf_m = 1'b1;
    if (act_m) begin
      t_m++;
      if (t_m == FRAME_LEN) act_m = 1'b0;
    end
    if (!act_m && q_m.size() > 0) begin
      cur_m = q_m.pop_front();
      act_m = 1'b1;
      t_m   = 0;
    end
    if (acc) q_m.push_back(d);
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    logic exp_tx;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    model_edge(v, d);
    exp_tx = act_m ? frame_bit(cur_m, t_m / CPB) : 1'b1;
    chk("tx", 8'(tx), 8'(exp_tx));
    chk("busy", 8'(busy), 8'(act_m || (q_m.size() > 0)));
    chk("in_ready", 8'(in_ready), 8'(q_m.size() < DEPTH));
    chk("overflow", 8'(overflow), 8'(ovf_m));
    tx_log.push_back(tx);
    busy_log.push_back(busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  initial begin
    int   base;
    logic exp_a5 [FRAME_BITS];
`ifdef LED_UART_PARITY_EN
    exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b1;
    model_reset();

    // Power-on reset values, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx", 8'(tx), 8'h01);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_in_ready", 8'(in_ready), 8'h01);
    chk("rst_overflow", 8'(overflow), 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single byte 0xA5: waveform sampled mid-bit, busy drop after the stop bit.
    tick(1'b1, 8'hA5);
    base = tx_log.size() - 1;
    idle(FRAME_LEN + 10);
    for (int i = 0; i < int'(FRAME_BITS); i++)
      chk($sformatf("a5_slot%0d", i), 8'(tx_log[base + 5 + 10 * i]), 8'(exp_a5[i]));
    chk("a5_busy_last", 8'(busy_log[base + FRAME_LEN]), 8'h01);
    chk("a5_busy_fall", 8'(busy_log[base + FRAME_LEN + 1]), 8'h00);

    // Back-to-back 0x01, 0x02: second start bit exactly one frame after the first.
    tick(1'b1, 8'h01);
    base = tx_log.size() - 1;
    tick(1'b1, 8'h02);
    idle(2 * FRAME_LEN + 10);
    chk("b2b_first_start", 8'(tx_log[base + 1]), 8'h00);
    chk("b2b_stop_end", 8'(tx_log[base + FRAME_LEN]), 8'h01);
    chk("b2b_second_start", 8'(tx_log[base + FRAME_LEN + 1]), 8'h00);
    chk("b2b_busy_gap", 8'(busy_log[base + FRAME_LEN + 1]), 8'h01);

    // Six bytes on consecutive edges: 0x15 is dropped, FIFO full, overflow sticks.
    for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h10 + i));
    chk("ovf_set", 8'(overflow), 8'h01);
    chk("ovf_full_ready", 8'(in_ready), 8'h00);
    idle(6 * FRAME_LEN);
    chk("ovf_drained_busy", 8'(busy), 8'h00);

    // Random traffic: light load, then heavy load that keeps the FIFO saturated.
    for (int i = 0; i < 700; i++) tick($urandom_range(0, 5) == 0, 8'($urandom));
    for (int i = 0; i < 300; i++) tick($urandom_range(0, 1) == 0, 8'($urandom));
    idle(6 * FRAME_LEN);

    // Mid-frame asynchronous reset with two bytes queued.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 8'hFF);
    tick(1'b1, 8'h3C);
    tick(1'b1, 8'hC3);
    idle(33);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", 8'(tx), 8'h01);
    chk("arst_busy", 8'(busy), 8'h00);
    chk("arst_in_ready", 8'(in_ready), 8'h01);
    chk("arst_overflow", 8'(overflow), 8'h00);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("arst_hold_tx", 8'(tx), 8'h01);
    rst_n = 1'b1;
    idle(3 * FRAME_LEN);
    chk("arst_quiet_busy", 8'(busy), 8'h00);

`ifdef LED_UART_PARITY_EN
    // Parity bit values and 11-bit frame length.
    tick(1'b1, 8'h07);
    base = tx_log.size() - 1;
    idle(FRAME_LEN + 5);
    chk("par07_bit", 8'(tx_log[base + 95]), 8'h01);
    chk("par07_busy_last", 8'(busy_log[base + 110]), 8'h01);
    chk("par07_busy_fall", 8'(busy_log[base + 111]), 8'h00);
    tick(1'b1, 8'h03);
    base = tx_log.size() - 1;
    idle(FRAME_LEN + 5);
    chk("par03_bit", 8'(tx_log[base + 95]), 8'h00);
    chk("par03_stop", 8'(tx_log[base + 105]), 8'h01);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
